sync_fifo: RTL and testbench



---
 rtl/sync_fifo.sv | 98 +++++++++
 tb/tb_sync_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with optional first-word-fall-through read, occupancy count and sticky error flags.
// Latency: write visible after 1 edge (FWFT) or popped onto rdata by the accepting read edge (standard).
// Backpressure: writes dropped while wfull (sets overflow), reads dropped while rempty (sets underflow).
module sync_fifo #(
    parameter int DSIZE      = 8,
    parameter int ASIZE      = 3,
    parameter int FWFT       = 0,
    parameter int AFULL_LVL  = 6,
    parameter int AEMPTY_LVL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             wfull,
    output logic             rempty,
    output logic             walmost_full,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE-1:0] wptr;
    logic [ASIZE-1:0] rptr;
    logic [ASIZE:0]   cnt_q;
    logic             wr_acc;
    logic             rd_acc;

    assign count         = cnt_q;
    assign wfull         = (cnt_q == (ASIZE+1)'(DEPTH));
    assign rempty        = (cnt_q == '0);
    assign walmost_full  = (cnt_q >= (ASIZE+1)'(AFULL_LVL));
    assign ralmost_empty = (cnt_q <= (ASIZE+1)'(AEMPTY_LVL));

    // Accept decisions use only registered flags, so no input reaches a flag combinationally.
    assign wr_acc = winc & ~wfull  & ~clr;
    assign rd_acc = rinc & ~rempty & ~clr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt_q     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + ASIZE'(1);
            if (rd_acc) rptr <= rptr + ASIZE'(1);
            case ({wr_acc, rd_acc})
                2'b10:   cnt_q <= cnt_q + (ASIZE+1)'(1);
                2'b01:   cnt_q <= cnt_q - (ASIZE+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (winc && wfull)  overflow  <= 1'b1;
            if (rinc && rempty) underflow <= 1'b1;
        end
    end

    // Storage is never cleared; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally from the array; zero while empty.
            assign rdata  = rempty ? '0 : mem[rptr];
            assign rvalid = ~rempty;
        end else begin : g_std
            logic [DSIZE-1:0] rdata_q;
            logic             rvalid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else if (clr) begin
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) rdata_q <= mem[rptr];
                end
            end

            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Drives a standard-mode and a FWFT-mode sync_fifo with identical directed stimulus and scores both
// against a queue model; a negedge monitor pops expected read data whenever a DUT presents a word.
module tb_sync_fifo;

    logic       clk;
    logic       rst, clr, winc, rinc;
    logic [7:0] wdata;

    logic [7:0] s_rdata, f_rdata;
    logic       s_rvalid, s_wfull, s_rempty, s_afull, s_aempty, s_ovf, s_unf;
    logic       f_rvalid, f_wfull, f_rempty, f_afull, f_aempty, f_ovf, f_unf;
    logic [3:0] s_count, f_count;

    int tests = 0;
    int fails = 0;

    // Reference model state, advanced once per rising edge by the stimulus task
    int         mcnt = 0;
    bit         mov = 0, mun = 0, mrv = 0;
    bit         mon_en = 0;
    logic [7:0] mq[$];
    logic [7:0] exp_std[$];

    sync_fifo #(.DSIZE(8), .ASIZE(3), .FWFT(0), .AFULL_LVL(6), .AEMPTY_LVL(2)) u_std (
        .clk(clk), .rst(rst), .clr(clr), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(s_rdata), .rvalid(s_rvalid), .wfull(s_wfull), .rempty(s_rempty),
        .walmost_full(s_afull), .ralmost_empty(s_aempty), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo #(.DSIZE(8), .ASIZE(3), .FWFT(1), .AFULL_LVL(6), .AEMPTY_LVL(2)) u_fw (
        .clk(clk), .rst(rst), .clr(clr), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(f_rdata), .rvalid(f_rvalid), .wfull(f_wfull), .rempty(f_rempty),
        .walmost_full(f_afull), .ralmost_empty(f_aempty), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, return at the next falling edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c, input logic rs);
        bit wa, ra;
        winc = w; wdata = d; rinc = r; clr = c; rst = rs;
        @(posedge clk);
        if (rs || c) begin
            mcnt = 0; mov = 0; mun = 0; mrv = 0;
            mq.delete();
            if (rs) exp_std.delete();
        end else begin
            wa = w && (mcnt != 8);
            ra = r && (mcnt != 0);
            if (w && !wa) mov = 1;
            if (r && !ra) mun = 1;
            mrv = ra;
            if (ra) exp_std.push_back(mq.pop_front());
            if (wa) mq.push_back(d);
            mcnt = mcnt + int'(wa) - int'(ra);
        end
        @(negedge clk);
    endtask

    // Monitor: flags/count every cycle, read data whenever a DUT presents a word
    always @(negedge clk) begin
        logic [10:0] es, ef;
        logic [7:0]  e;
        if (mon_en) begin
            es = {mrv,       mcnt == 8, mcnt == 0, mcnt >= 6, mcnt <= 2, mov, mun, 4'(mcnt)};
            ef = {mcnt != 0, mcnt == 8, mcnt == 0, mcnt >= 6, mcnt <= 2, mov, mun, 4'(mcnt)};
            chk("status_std", {s_rvalid, s_wfull, s_rempty, s_afull, s_aempty, s_ovf, s_unf, s_count}, 32'(es));
            chk("status_fwft", {f_rvalid, f_wfull, f_rempty, f_afull, f_aempty, f_ovf, f_unf, f_count}, 32'(ef));
            if (s_rvalid === 1'b1) begin
                if (exp_std.size() == 0) chk("rdata_std_unexpected", 32'(s_rdata), 32'hFFFF_FFFF);
                else begin
                    e = exp_std.pop_front();
                    chk("rdata_std", 32'(s_rdata), 32'(e));
                end
            end
            if (f_rempty === 1'b0) begin
                if (mq.size() == 0) chk("rdata_fwft_unexpected", 32'(f_rdata), 32'hFFFF_FFFF);
                else chk("rdata_fwft", 32'(f_rdata), 32'(mq[0]));
            end
        end
    end

    initial begin
        int c;
        rst = 1'b1; clr = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;

        // Reset
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        chk("rst_count", 32'(s_count), 0);
        chk("rst_rempty", 32'({s_rempty, f_rempty}), 32'h3);
        chk("rst_wfull", 32'({s_wfull, f_wfull}), 0);
        chk("rst_aempty_afull", 32'({s_aempty, s_afull}), 32'h2);
        chk("rst_flags", 32'({s_ovf, s_unf, f_ovf, f_unf}), 0);
        chk("rst_rvalid", 32'({s_rvalid, f_rvalid}), 0);
        chk("rst_rdata", 32'({s_rdata, f_rdata}), 0);
        mon_en = 1;

        // Fill 0x00..0x0A, last three dropped
        for (int i = 0; i < 11; i++) begin
            step(1, 8'(i), 0, 0, 0);
            c = (i < 8) ? i + 1 : 8;
            chk("fill_count", 32'(s_count), 32'(c));
            chk("fill_afull", 32'(s_afull), 32'(c >= 6));
        end
        chk("fill_wfull", 32'(s_wfull), 1);
        chk("fill_overflow", 32'({s_ovf, f_ovf}), 32'h3);

        // Drain 11 reads, last three rejected
        for (int i = 0; i < 11; i++) begin
            if (i < 8) chk("drain_fwft_head", 32'(f_rdata), 32'(i));
            step(0, 8'h00, 1, 0, 0);
            c = (i < 8) ? 7 - i : 0;
            if (i < 8) begin
                chk("drain_std_data", 32'(s_rdata), 32'(i));
                chk("drain_std_rvalid", 32'(s_rvalid), 1);
            end
            chk("drain_count", 32'(s_count), 32'(c));
            chk("drain_aempty", 32'(s_aempty), 32'(c <= 2));
        end
        chk("drain_rempty", 32'(s_rempty), 1);
        chk("drain_underflow", 32'({s_unf, f_unf}), 32'h3);
        chk("drain_rvalid_idle", 32'(s_rvalid), 0);

        // Simultaneous traffic across pointer wrap
        step(0, 8'h00, 0, 1, 0);
        chk("clr_flags", 32'({s_ovf, s_unf}), 0);
        for (int i = 0; i < 4; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(8'h24 + i), 1, 0, 0);
            chk("wrap_count", 32'(s_count), 4);
            chk("wrap_std_data", 32'(s_rdata), 32'(8'h20 + i));
        end

        // Full with both requests: read only
        for (int i = 0; i < 4; i++) step(1, 8'(8'h38 + i), 0, 0, 0);
        chk("full_count", 32'(s_count), 8);
        step(1, 8'hEE, 1, 0, 0);
        chk("full_rw_count", 32'(s_count), 7);
        chk("full_rw_overflow", 32'(s_ovf), 1);
        chk("full_rw_data", 32'(s_rdata), 32'h34);

        // Empty with both requests: write only
        for (int i = 0; i < 7; i++) step(0, 8'h00, 1, 0, 0);
        chk("empty_before", 32'(s_rempty), 1);
        step(1, 8'h77, 1, 0, 0);
        chk("empty_rw_count", 32'(s_count), 1);
        chk("empty_rw_underflow", 32'(s_unf), 1);
        chk("empty_rw_fwft_data", 32'(f_rdata), 32'h77);

        // Flush at count 5 with overflow set; same-cycle requests ignored
        for (int i = 0; i < 4; i++) step(1, 8'(8'h78 + i), 0, 0, 0);
        chk("pre_clr_count", 32'(s_count), 5);
        chk("pre_clr_overflow", 32'(s_ovf), 1);
        step(1, 8'h99, 1, 1, 0);
        chk("clr_count", 32'({s_count, f_count}), 0);
        chk("clr_rempty", 32'({s_rempty, f_rempty}), 32'h3);
        chk("clr_ovf_unf", 32'({s_ovf, s_unf, f_ovf, f_unf}), 0);

        // FWFT latency and standard rvalid pulse
        step(1, 8'h00, 0, 0, 0);
        chk("fwft_first_word", 32'({f_rvalid, f_rdata}), 32'h100);
        chk("std_no_rvalid", 32'(s_rvalid), 0);
        step(1, 8'hA5, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        chk("std_pulse", 32'({s_rvalid, s_rdata}), 32'h100);
        chk("fwft_next_head", 32'(f_rdata), 32'hA5);
        step(0, 8'h00, 0, 0, 0);
        chk("std_pulse_end", 32'(s_rvalid), 0);

        // Reset during traffic
        for (int i = 0; i < 3; i++) step(1, 8'(8'h11 * (i + 1)), 1, 0, 0);
        step(1, 8'h44, 1, 0, 1);
        chk("midrst_count", 32'({s_count, f_count}), 0);
        chk("midrst_flags", 32'({s_rempty, s_aempty, s_afull, s_wfull, s_ovf, s_unf}), 32'h30);
        chk("midrst_rvalid", 32'({s_rvalid, f_rvalid}), 0);
        chk("midrst_rdata", 32'({s_rdata, f_rdata}), 0);
        step(0, 8'h00, 0, 0, 0);
        chk("end_std_queue", 32'(exp_std.size()), 0);

        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
